// File: rtl/hline_setup_pkg.sv
// Shared definitions for the span setup stage and the downstream z-buffer FSM:
// state codes, geometry constants and the latched span command layout.
package hline_pkg;

  localparam int LOG2_STRIDE = 12;
  localparam int DIV_STEPS   = 32;
  localparam logic [4:0] DIV_CNT_LAST = 5'(DIV_STEPS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_DIV       = 3'd2;
  localparam logic [2:0] S_FIX       = 3'd3;
  localparam logic [2:0] S_ISSUE     = 3'd4;
  localparam logic [2:0] S_WAIT_ACK  = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;

  typedef struct packed {
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] y;
    logic [31:0] z1;
    logic [31:0] z2;
    logic [31:0] rgbx;
    logic [31:0] fb_base;
    logic [31:0] zbuff_base;
  } span_cmd_t;

  // Magnitude of a 33-bit two's complement difference of two unsigned 32-bit values.
  function automatic logic [31:0] mag33(input logic [32:0] v);
    logic [32:0] t;
    t = v[32] ? (33'd0 - v) : v;
    return t[31:0];
  endfunction

endpackage

// File: rtl/hline_setup_if.sv
// Span command in, FSM start/done handshake and span parameters out.
interface hline_setup_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] x1;
  logic [15:0] x2;
  logic [15:0] y;
  logic [31:0] z1_in;
  logic [31:0] z2_in;
  logic [31:0] rgbx_in;
  logic [31:0] fb_base;
  logic [31:0] zbuff_base;
  logic        start;
  logic        done;
  logic [31:0] fb_addr;
  logic [31:0] zbuff_addr;
  logic [31:0] dx;
  logic [31:0] slope;
  logic [31:0] z1;
  logic [31:0] rem;
  logic [31:0] err;
  logic [31:0] rgbx;
  logic        busy;
  logic [15:0] line_count;

  modport slave (
    input  cmd_valid, x1, x2, y, z1_in, z2_in, rgbx_in, fb_base, zbuff_base, done,
    output cmd_ready, start, fb_addr, zbuff_addr, dx, slope, z1, rem, err, rgbx,
           busy, line_count
  );

  modport master (
    output cmd_valid, x1, x2, y, z1_in, z2_in, rgbx_in, fb_base, zbuff_base, done,
    input  cmd_ready, start, fb_addr, zbuff_addr, dx, slope, z1, rem, err, rgbx,
           busy, line_count
  );

endinterface

// File: rtl/hline_setup_udiv32.sv
// Sequential 32/32 unsigned restoring divider, one quotient bit per cycle,
// fixed 32-cycle latency after a go pulse.
module udiv32
  import hline_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        go,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvsr;
  logic [32:0] w_part;
  logic [32:0] w_trial;

  // Partial remainder with next dividend bit shifted in, and trial subtraction.
  always_comb begin
    w_part  = {r_rem, r_quo[31]};
    w_trial = w_part - {1'b0, r_dvsr};
  end

  // Divider datapath and step counter.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_busy <= 1'b0;
      r_cnt  <= 5'd0;
      r_quo  <= 32'd0;
      r_rem  <= 32'd0;
      r_dvsr <= 32'd0;
    end else if (go) begin
      r_busy <= 1'b1;
      r_cnt  <= 5'd0;
      r_quo  <= dividend;
      r_rem  <= 32'd0;
      r_dvsr <= divisor;
    end else if (r_busy) begin
      // A restore leaves w_part[32] clear, so dropping it loses nothing.
      if (!w_trial[32]) begin
        r_rem <= w_trial[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_part[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
      r_cnt  <= r_cnt + 5'd1;
      r_busy <= (r_cnt != DIV_CNT_LAST);
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign busy      = r_busy;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/hline_setup.sv
// Per-span setup ahead of the hline z-buffer FSM: orders endpoints, divides the
// depth delta by the span length, forms start addresses and hands off via start/done.
module hline_setup
  import hline_pkg::*;
#(
  parameter int LOG2_STRIDE = hline_pkg::LOG2_STRIDE
) (
  input logic          clk,
  input logic          nreset,
  hline_setup_if.slave io_bus
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nx;
  span_cmd_t   r_cmd;
  logic [4:0]  r_div_cnt;
  logic        r_dz_neg;

  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_start;
  logic [15:0] r_line_count;
  logic [31:0] r_fb_addr;
  logic [31:0] r_zbuff_addr;
  logic [31:0] r_dx;
  logic [31:0] r_slope;
  logic [31:0] r_z1;
  logic [31:0] r_rem;
  logic [31:0] r_err;
  logic [31:0] r_rgbx;

  logic        w_swap;
  logic [15:0] w_xl;
  logic [15:0] w_xr;
  logic [31:0] w_zl;
  logic [31:0] w_zr;
  logic [31:0] w_dx;
  logic [32:0] w_dz;
  logic [31:0] w_dz_mag;
  logic [31:0] w_row_off;
  logic [31:0] w_col_off;
  logic [31:0] w_fb_addr;
  logic [31:0] w_zb_addr;
  logic        w_div_go;
  logic        w_div_busy;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Endpoint ordering, span length, depth delta and start addresses from the latched command.
  always_comb begin
    w_swap = (r_cmd.x1 > r_cmd.x2);
    if (w_swap) begin
      w_xl = r_cmd.x2;
      w_xr = r_cmd.x1;
      w_zl = r_cmd.z2;
      w_zr = r_cmd.z1;
    end else begin
      w_xl = r_cmd.x1;
      w_xr = r_cmd.x2;
      w_zl = r_cmd.z1;
      w_zr = r_cmd.z2;
    end
    w_dx      = {16'd0, w_xr} - {16'd0, w_xl} + 32'd1;
    w_dz      = {1'b0, w_zr} - {1'b0, w_zl};
    w_dz_mag  = mag33(w_dz);
    w_row_off = {16'd0, r_cmd.y} << LOG2_STRIDE;
    w_col_off = {14'd0, w_xl, 2'b00};
    w_fb_addr = r_cmd.fb_base + w_row_off + w_col_off;
    w_zb_addr = r_cmd.zbuff_base + w_row_off + w_col_off;
  end

  assign w_div_go = (r_state == S_SETUP);

  udiv32 u_div (
    .clk       (clk),
    .nreset    (nreset),
    .go        (w_div_go),
    .dividend  (w_dz_mag),
    .divisor   (w_dx),
    .busy      (w_div_busy),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Next-state logic; a stale done in WAIT_ACK must drop before a completion counts.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.cmd_valid) w_state_nx = S_SETUP;
        else                  w_state_nx = S_IDLE;
      end
      S_SETUP: w_state_nx = S_DIV;
      S_DIV: begin
        if ((r_div_cnt == DIV_CNT_LAST) || !w_div_busy) w_state_nx = S_FIX;
        else                                            w_state_nx = S_DIV;
      end
      S_FIX:   w_state_nx = S_ISSUE;
      S_ISSUE: w_state_nx = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!io_bus.done) w_state_nx = S_WAIT_DONE;
        else              w_state_nx = S_WAIT_ACK;
      end
      S_WAIT_DONE: begin
        if (io_bus.done) w_state_nx = S_IDLE;
        else             w_state_nx = S_WAIT_DONE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register, handshake flags and completed-span counter.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_start      <= 1'b0;
      r_div_cnt    <= 5'd0;
      r_line_count <= 16'd0;
    end else begin
      r_state     <= w_state_nx;
      r_cmd_ready <= (w_state_nx == S_IDLE);
      r_busy      <= (w_state_nx != S_IDLE);
      r_start     <= (w_state_nx == S_ISSUE);
      if (r_state == S_DIV) r_div_cnt <= r_div_cnt + 5'd1;
      else                  r_div_cnt <= 5'd0;
      if ((r_state == S_WAIT_DONE) && io_bus.done) r_line_count <= r_line_count + 16'd1;
      else                                         r_line_count <= r_line_count;
    end
  end

  // Command capture in IDLE; span parameters load in SETUP and FIX and hold otherwise.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_cmd        <= '0;
      r_dz_neg     <= 1'b0;
      r_fb_addr    <= 32'd0;
      r_zbuff_addr <= 32'd0;
      r_dx         <= 32'd0;
      r_slope      <= 32'd0;
      r_z1         <= 32'd0;
      r_rem        <= 32'd0;
      r_err        <= 32'd0;
      r_rgbx       <= 32'd0;
    end else begin
      if ((r_state == S_IDLE) && io_bus.cmd_valid) begin
        r_cmd.x1         <= io_bus.x1;
        r_cmd.x2         <= io_bus.x2;
        r_cmd.y          <= io_bus.y;
        r_cmd.z1         <= io_bus.z1_in;
        r_cmd.z2         <= io_bus.z2_in;
        r_cmd.rgbx       <= io_bus.rgbx_in;
        r_cmd.fb_base    <= io_bus.fb_base;
        r_cmd.zbuff_base <= io_bus.zbuff_base;
      end
      if (r_state == S_SETUP) begin
        r_dz_neg     <= w_dz[32];
        r_fb_addr    <= w_fb_addr;
        r_zbuff_addr <= w_zb_addr;
        r_dx         <= w_dx;
        r_z1         <= w_zl;
        r_rgbx       <= r_cmd.rgbx;
      end
      // Negating the magnitude quotient gives truncation toward zero.
      if (r_state == S_FIX) begin
        r_slope <= r_dz_neg ? (32'd0 - w_quo) : w_quo;
        r_rem   <= w_rem;
        r_err   <= 32'd0;
      end
    end
  end

  assign io_bus.cmd_ready  = r_cmd_ready;
  assign io_bus.busy       = r_busy;
  assign io_bus.start      = r_start;
  assign io_bus.line_count = r_line_count;
  assign io_bus.fb_addr    = r_fb_addr;
  assign io_bus.zbuff_addr = r_zbuff_addr;
  assign io_bus.dx         = r_dx;
  assign io_bus.slope      = r_slope;
  assign io_bus.z1         = r_z1;
  assign io_bus.rem        = r_rem;
  assign io_bus.err        = r_err;
  assign io_bus.rgbx       = r_rgbx;

endmodule

// File: tb/tb_hline_setup.sv
// Directed self-checking bench for hline_setup: latency, arithmetic, handshake, reset.
module tb_hline_setup;

  logic clk;
  logic nreset;
  int checks;
  int errors;
  logic [15:0] exp_lc;

  hline_setup_if bus ();

  hline_setup dut (
    .clk    (clk),
    .nreset (nreset),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic accept(input logic [15:0] x1, x2, y, input logic [31:0] z1, z2, fbb, zbb, rgb,
                        input bit hold, input string nm);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b exp 1", nm, bus.cmd_ready);
    end
    bus.x1 = x1; bus.x2 = x2; bus.y = y;
    bus.z1_in = z1; bus.z2_in = z2;
    bus.fb_base = fbb; bus.zbuff_base = zbb; bus.rgbx_in = rgb;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  // Accepts a span, then samples each following cycle up to T+36.
  task automatic run_span(input logic [15:0] x1, x2, y, input logic [31:0] z1, z2, fbb, zbb, rgb,
                          input logic [31:0] e_dx, e_slope, e_z1, e_rem, e_fb, e_zb,
                          input bit hold, input string nm);
    int start_at;
    int pulses;
    start_at = 0;
    pulses = 0;
    accept(x1, x2, y, z1, z2, fbb, zbb, rgb, hold, nm);
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      if (bus.start === 1'b1) begin
        pulses++;
        if (start_at == 0) start_at = i;
      end
      if (i == 1) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_busy got busy=%b ready=%b exp 1/0", nm, bus.busy, bus.cmd_ready);
        end
      end
      if (i == 35) begin
        checks++;
        if (bus.dx !== e_dx) begin errors++; $display("FAIL %s_dx got %h exp %h", nm, bus.dx, e_dx); end
        checks++;
        if (bus.slope !== e_slope) begin errors++; $display("FAIL %s_slope got %h exp %h", nm, bus.slope, e_slope); end
        checks++;
        if (bus.z1 !== e_z1) begin errors++; $display("FAIL %s_z1 got %h exp %h", nm, bus.z1, e_z1); end
        checks++;
        if (bus.rem !== e_rem) begin errors++; $display("FAIL %s_rem got %h exp %h", nm, bus.rem, e_rem); end
        checks++;
        if (bus.err !== 32'd0) begin errors++; $display("FAIL %s_err got %h exp 0", nm, bus.err); end
        checks++;
        if (bus.rgbx !== rgb) begin errors++; $display("FAIL %s_rgbx got %h exp %h", nm, bus.rgbx, rgb); end
        checks++;
        if (bus.fb_addr !== e_fb) begin errors++; $display("FAIL %s_fb got %h exp %h", nm, bus.fb_addr, e_fb); end
        checks++;
        if (bus.zbuff_addr !== e_zb) begin errors++; $display("FAIL %s_zb got %h exp %h", nm, bus.zbuff_addr, e_zb); end
      end
    end
    checks++;
    if (start_at != 35) begin errors++; $display("FAIL %s_start_cycle got %0d exp 35", nm, start_at); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL %s_start_pulses got %0d exp 1", nm, pulses); end
  endtask

  task automatic finish_span(input string nm);
    bus.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.line_count !== exp_lc) begin
      errors++;
      $display("FAIL %s_wait got ready=%b lc=%h exp 0/%h", nm, bus.cmd_ready, bus.line_count, exp_lc);
    end
    bus.done = 1'b1;
    @(negedge clk);
    exp_lc = exp_lc + 16'd1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.line_count !== exp_lc) begin
      errors++;
      $display("FAIL %s_complete got ready=%b busy=%b lc=%h exp 1/0/%h",
               nm, bus.cmd_ready, bus.busy, bus.line_count, exp_lc);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus.cmd_valid = 1'b0; bus.done = 1'b0;
    bus.x1 = 16'd0; bus.x2 = 16'd0; bus.y = 16'd0;
    bus.z1_in = 32'd0; bus.z2_in = 32'd0; bus.rgbx_in = 32'd0;
    bus.fb_base = 32'd0; bus.zbuff_base = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.line_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl got ready=%b busy=%b start=%b lc=%h exp 1/0/0/0",
               bus.cmd_ready, bus.busy, bus.start, bus.line_count);
    end
    checks++;
    if ((bus.fb_addr | bus.zbuff_addr | bus.dx | bus.slope | bus.z1 | bus.rem | bus.err | bus.rgbx) !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got fb=%h zb=%h dx=%h slope=%h z1=%h rem=%h err=%h rgbx=%h exp all 0",
               bus.fb_addr, bus.zbuff_addr, bus.dx, bus.slope, bus.z1, bus.rem, bus.err, bus.rgbx);
    end
    nreset = 1'b1;
    exp_lc = 16'd0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_span(16'd10, 16'd19, 16'd2, 32'd100, 32'd200, 32'h1000_0000, 32'h2000_0000, 32'hAABB_CCDD,
             32'd10, 32'd10, 32'd100, 32'd0, 32'h1000_2028, 32'h2000_2028, 1'b0, "basic");
    finish_span("basic");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.dx !== 32'd10 || bus.fb_addr !== 32'h1000_2028 || bus.slope !== 32'd10) begin
      errors++;
      $display("FAIL idle_hold got dx=%h fb=%h slope=%h exp 0000000a/10002028/0000000a",
               bus.dx, bus.fb_addr, bus.slope);
    end
  endtask

  task automatic test_swap();
    run_span(16'd19, 16'd10, 16'd3, 32'd200, 32'd100, 32'h1000_0000, 32'h2000_0000, 32'h0102_0304,
             32'd10, 32'd10, 32'd100, 32'd0, 32'h1000_3028, 32'h2000_3028, 1'b0, "swap_pos");
    finish_span("swap_pos");
    run_span(16'd19, 16'd10, 16'd3, 32'd100, 32'd200, 32'h1000_0000, 32'h2000_0000, 32'h0506_0708,
             32'd10, 32'hFFFF_FFF6, 32'd200, 32'd0, 32'h1000_3028, 32'h2000_3028, 1'b0, "swap_neg");
    finish_span("swap_neg");
  endtask

  task automatic test_boundary();
    run_span(16'd5, 16'd5, 16'd0, 32'd7, 32'd7, 32'h0000_0100, 32'h0000_0200, 32'h1111_1111,
             32'd1, 32'd0, 32'd7, 32'd0, 32'h0000_0114, 32'h0000_0214, 1'b0, "single_px");
    finish_span("single_px");
    run_span(16'd0, 16'd2, 16'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0000_0000, 32'h2222_2222,
             32'd3, 32'h5555_5555, 32'd0, 32'd0, 32'h0000_0000, 32'h0000_1000, 1'b0, "max_dz_wrap");
    finish_span("max_dz_wrap");
    run_span(16'd0, 16'hFFFF, 16'd0, 32'd0, 32'h0003_0005, 32'h0000_0010, 32'h0000_0020, 32'h3333_3333,
             32'h0001_0000, 32'd3, 32'd0, 32'd5, 32'h0000_0010, 32'h0000_0020, 1'b0, "max_dx");
    finish_span("max_dx");
  endtask

  task automatic test_remainder();
    run_span(16'd0, 16'd2, 16'd0, 32'd10, 32'd3, 32'd0, 32'd0, 32'h4444_4444,
             32'd3, 32'hFFFF_FFFE, 32'd10, 32'd1, 32'd0, 32'd0, 1'b0, "neg_rem");
    finish_span("neg_rem");
    run_span(16'd100, 16'd109, 16'd1, 32'd0, 32'd7, 32'd0, 32'd0, 32'h5555_5555,
             32'd10, 32'd0, 32'd0, 32'd7, 32'h0000_1190, 32'h0000_1190, 1'b0, "small_dz");
    finish_span("small_dz");
  endtask

  task automatic test_done_handshake();
    int n;
    bus.done = 1'b1;
    run_span(16'd10, 16'd19, 16'd2, 32'd100, 32'd200, 32'h1000_0000, 32'h2000_0000, 32'h6666_6666,
             32'd10, 32'd10, 32'd100, 32'd0, 32'h1000_2028, 32'h2000_2028, 1'b1, "hs");
    for (int i = 37; i <= 38; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.line_count !== exp_lc) begin
        errors++;
        $display("FAIL hs_stale_done got ready=%b lc=%h exp 0/%h", bus.cmd_ready, bus.line_count, exp_lc);
      end
    end
    bus.done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b0 || bus.line_count !== exp_lc) begin
        errors++;
        $display("FAIL hs_low got ready=%b lc=%h exp 0/%h", bus.cmd_ready, bus.line_count, exp_lc);
      end
    end
    bus.done = 1'b1;
    @(negedge clk);
    exp_lc = exp_lc + 16'd1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.line_count !== exp_lc) begin
      errors++;
      $display("FAIL hs_complete got ready=%b lc=%h exp 1/%h", bus.cmd_ready, bus.line_count, exp_lc);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL hs_reaccept got ready=%b busy=%b exp 0/1", bus.cmd_ready, bus.busy);
    end
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.start !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.start !== 1'b1) begin
      errors++;
      $display("FAIL hs_second_start got %b exp 1", bus.start);
    end
    finish_span("hs_second");
  endtask

  task automatic test_reset_mid();
    accept(16'd0, 16'd2, 16'd0, 32'd10, 32'd3, 32'h0000_4000, 32'h0000_8000, 32'h7777_7777, 1'b0, "rst_div");
    repeat (10) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.line_count !== 16'd0 ||
        bus.dx !== 32'd0 || bus.slope !== 32'd0 || bus.fb_addr !== 32'd0 || bus.rgbx !== 32'd0) begin
      errors++;
      $display("FAIL rst_div got ready=%b busy=%b start=%b lc=%h dx=%h slope=%h fb=%h rgbx=%h exp 1/0/0/0/0/0/0/0",
               bus.cmd_ready, bus.busy, bus.start, bus.line_count, bus.dx, bus.slope, bus.fb_addr, bus.rgbx);
    end
    nreset = 1'b1;
    exp_lc = 16'd0;
    run_span(16'd100, 16'd109, 16'd1, 32'd0, 32'd7, 32'd0, 32'd0, 32'h8888_8888,
             32'd10, 32'd0, 32'd0, 32'd7, 32'h0000_1190, 32'h0000_1190, 1'b0, "post_rst");
    finish_span("post_rst");
    run_span(16'd0, 16'd2, 16'd0, 32'd10, 32'd3, 32'd0, 32'd0, 32'h9999_9999,
             32'd3, 32'hFFFF_FFFE, 32'd10, 32'd1, 32'd0, 32'd0, 1'b0, "rst_wd");
    bus.done = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.line_count !== 16'd0 ||
        bus.dx !== 32'd0 || bus.z1 !== 32'd0 || bus.rem !== 32'd0 || bus.zbuff_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_wait_done got ready=%b busy=%b start=%b lc=%h dx=%h z1=%h rem=%h zb=%h exp 1/0/0/0/0/0/0/0",
               bus.cmd_ready, bus.busy, bus.start, bus.line_count, bus.dx, bus.z1, bus.rem, bus.zbuff_addr);
    end
    nreset = 1'b1;
    exp_lc = 16'd0;
    run_span(16'd10, 16'd19, 16'd2, 32'd100, 32'd200, 32'h1000_0000, 32'h2000_0000, 32'hAABB_CCDD,
             32'd10, 32'd10, 32'd100, 32'd0, 32'h1000_2028, 32'h2000_2028, 1'b0, "fresh");
    finish_span("fresh");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_lc = 16'd0;
    test_reset();
    test_basic();
    test_swap();
    test_boundary();
    test_remainder();
    test_done_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
